// File: rtl/i2c_target.sv
// I2C target endpoint: synchronizes and deglitches raw SCL/SDA, detects
// START/STOP, matches a 7-bit address and exchanges bytes with user logic
// through single-cycle strobes. No clock stretching.

// Two-flop synchronizer followed by a consecutive-sample glitch filter.
module i2c_target_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_filt;

  // Synchronize the pad, then flip the filtered value only after FILTER_LEN
  // consecutive disagreeing samples.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples the pre-edge values, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

module i2c_target #(
  parameter logic [6:0] ADDR       = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  logic w_scl_f, w_sda_f;
  logic r_scl_d, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [6:0] r_tx_shift, w_tx_shift_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_start, w_start_nxt;
  logic       r_stop, w_stop_nxt;

  i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .i_raw(scl_i), .o_filt(w_scl_f)
  );

  i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .i_raw(sda_i), .o_filt(w_sda_f)
  );

  // Delayed copies of the filtered lines for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl_f;
      r_sda_d <= w_sda_f;
    end
  end

  assign w_scl_rise = w_scl_f & ~r_scl_d;
  assign w_scl_fall = ~w_scl_f & r_scl_d;
  assign w_start    = ~w_sda_f & r_sda_d & w_scl_f & r_scl_d;
  assign w_stop     = w_sda_f & ~r_sda_d & w_scl_f & r_scl_d;

  // State and output registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_sda_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_start    <= w_start_nxt;
      r_stop     <= w_stop_nxt;
    end
  end

  // Next-state and next-output logic; bus conditions override SCL edges.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_sda_oe_nxt   = r_sda_oe;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_start_nxt    = 1'b0;
    w_stop_nxt     = 1'b0;

    if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b1;
      w_start_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_stop_nxt   = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda_f};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_nxt = '0;
            if (r_shift[7:1] == ADDR) begin
              w_state_nxt  = S_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_rw_nxt     = r_shift[0];
            end else begin
              w_state_nxt  = S_WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_rise && r_rw) begin
            w_tx_req_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_cnt_nxt = '0;
            if (!r_rw) begin
              w_state_nxt  = S_RX;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_state_nxt    = S_TX;
              w_tx_shift_nxt = tx_data[6:0];
              w_sda_oe_nxt   = ~tx_data[7];
            end
          end
        end
        S_RX: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda_f};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_rx_data_nxt  = {r_shift[6:0], w_sda_f};
              w_rx_valid_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nxt  = S_RX_ACK;
            w_sda_oe_nxt = rx_ack;
            w_cnt_nxt    = '0;
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = S_RX;
            w_sda_oe_nxt = 1'b0;
          end
        end
        S_TX: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd7) begin
              w_state_nxt  = S_TX_ACK;
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
            end else begin
              w_sda_oe_nxt   = ~r_tx_shift[6];
              w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
              w_cnt_nxt      = r_cnt + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          // r_cnt marks that the ACK-clock rise has been seen with an ACK.
          if (w_scl_rise) begin
            if (!w_sda_f) begin
              w_tx_req_nxt = 1'b1;
              w_cnt_nxt    = 4'd1;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_state_nxt    = S_TX;
            w_tx_shift_nxt = tx_data[6:0];
            w_sda_oe_nxt   = ~tx_data[7];
            w_cnt_nxt      = '0;
          end
        end
        S_WAIT_STOP: w_sda_oe_nxt = 1'b0;
        S_IDLE:      w_sda_oe_nxt = 1'b0;
        default:     w_state_nxt  = S_IDLE;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign rw        = r_rw;
  assign busy      = r_busy;
  assign start_det = r_start;
  assign stop_det  = r_stop;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged 400 kHz master drives the
// open-drain bus; a negedge monitor scores rx bytes against a queue.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_i = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ack = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       w_sda;
  logic       sda_oe, rx_valid, tx_req, rw, busy, start_det, stop_det;
  logic [7:0] rx_data;

  // Open-drain bus: either side can pull low.
  assign w_sda = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(w_sda),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .tx_data(tx_data), .tx_req(tx_req), .rw(rw),
    .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_q[$];
  int n_rx = 0, n_spur = 0, n_txreq = 0, n_start = 0, n_stop = 0;
  bit oe_seen = 1'b0, busy_arm = 1'b0, busy_drop = 1'b0;

  // Monitor: score rx bytes, serve tx_data on request, count strobes.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      if (rx_exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
      else n_spur++;
    end
    if (tx_req) begin
      n_txreq++;
      tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
    end
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy_arm && !busy) busy_drop = 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting just after a fall; returns SDA sampled mid-high.
  task automatic clock_bit(input bit b, input bit glitch, output bit s);
    wait_cyc(65);
    m_sda = b;
    if (glitch) begin
      wait_cyc(20); scl_i = 1'b1; wait_cyc(2); scl_i = 1'b0; wait_cyc(43);
    end else wait_cyc(65);
    scl_i = 1'b1;
    if (glitch) begin
      wait_cyc(20); scl_i = 1'b0; wait_cyc(2); scl_i = 1'b1; wait_cyc(38);
    end else wait_cyc(60);
    s = w_sda;
    wait_cyc(60);
    scl_i = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_cyc(65);
    scl_i = 1'b1; wait_cyc(60);
    m_sda = 1'b0; wait_cyc(60);
    scl_i = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(65); m_sda = 1'b0;
    wait_cyc(65); scl_i = 1'b1;
    wait_cyc(60); m_sda = 1'b1;
    wait_cyc(60);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, input bit chk_lat, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], glitch, s);
    if (chk_lat) begin
      wait_cyc(5); check("oe_lat5", 32'(sda_oe), 32'd0);
      wait_cyc(1); check("oe_lat6", 32'(sda_oe), 32'd1);
    end
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    clock_bit(~mack, 1'b0, s);
  endtask

  initial begin
    bit         ack;
    logic [7:0] rd;
    int         rx0, st0, sp0, tr0;

    // Reset values
    wait_cyc(3);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_req", 32'(tx_req), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(start_det), 0);
    check("rst_stop", 32'(stop_det), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Write to 0x50: 0x3C, 0xC3
    rx0 = n_rx; sp0 = n_stop;
    rx_exp_q.push_back(8'h3C); rx_exp_q.push_back(8'hC3);
    i2c_start();
    check("w_busy", 32'(busy), 1);
    write_byte(8'hA0, 1'b0, 1'b1, ack); check("w_ack_addr", 32'(ack), 1);
    check("w_rw", 32'(rw), 0);
    write_byte(8'h3C, 1'b0, 1'b0, ack); check("w_ack_d0", 32'(ack), 1);
    write_byte(8'hC3, 1'b0, 1'b0, ack); check("w_ack_d1", 32'(ack), 1);
    i2c_stop(); wait_cyc(20);
    check("w_rx_cnt", 32'(n_rx - rx0), 2);
    check("w_stop_cnt", 32'(n_stop - sp0), 1);
    check("w_busy_end", 32'(busy), 0);
    check("w_rx_last", 32'(rx_data), 32'h00C3);

    // Address 0x51: never acknowledged
    rx0 = n_rx; oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b0, 1'b0, ack); check("na_ack_addr", 32'(ack), 0);
    write_byte(8'h12, 1'b0, 1'b0, ack); check("na_ack_d0", 32'(ack), 0);
    i2c_stop(); wait_cyc(20);
    check("na_oe_seen", 32'(oe_seen), 0);
    check("na_rx_cnt", 32'(n_rx - rx0), 0);
    check("na_busy", 32'(busy), 0);

    // Read 0xA1: 0x5A (ACK) then 0x81 (NACK)
    tr0 = n_txreq;
    tx_q.push_back(8'h5A); tx_q.push_back(8'h81);
    i2c_start();
    write_byte(8'hA1, 1'b0, 1'b0, ack); check("r_ack_addr", 32'(ack), 1);
    check("r_rw", 32'(rw), 1);
    read_byte(1'b1, rd); check("r_byte0", 32'(rd), 32'h5A);
    read_byte(1'b0, rd); check("r_byte1", 32'(rd), 32'h81);
    wait_cyc(20);
    check("r_release", 32'(sda_oe), 0);
    check("r_busy_mid", 32'(busy), 1);
    i2c_stop(); wait_cyc(20);
    check("r_txreq_cnt", 32'(n_txreq - tr0), 2);
    check("r_busy_end", 32'(busy), 0);

    // Write 0x11, repeated START, read 0x77
    st0 = n_start; rx0 = n_rx;
    rx_exp_q.push_back(8'h11); tx_q.push_back(8'h77);
    i2c_start();
    busy_drop = 1'b0; busy_arm = 1'b1;
    write_byte(8'hA0, 1'b0, 1'b0, ack); check("rs_ack_addr", 32'(ack), 1);
    write_byte(8'h11, 1'b0, 1'b0, ack); check("rs_ack_d0", 32'(ack), 1);
    check("rs_rw_w", 32'(rw), 0);
    i2c_start();
    write_byte(8'hA1, 1'b0, 1'b0, ack); check("rs_ack_addr2", 32'(ack), 1);
    read_byte(1'b0, rd); check("rs_rbyte", 32'(rd), 32'h77);
    check("rs_rw_r", 32'(rw), 1);
    busy_arm = 1'b0;
    i2c_stop(); wait_cyc(20);
    check("rs_start_cnt", 32'(n_start - st0), 2);
    check("rs_busy_drop", 32'(busy_drop), 0);
    check("rs_rx_cnt", 32'(n_rx - rx0), 1);

    // SCL glitches during data bits; NACK on the second byte
    rx0 = n_rx;
    rx_exp_q.push_back(8'h96); rx_exp_q.push_back(8'h69);
    i2c_start();
    write_byte(8'hA0, 1'b0, 1'b0, ack); check("g_ack_addr", 32'(ack), 1);
    write_byte(8'h96, 1'b1, 1'b0, ack); check("g_ack_d0", 32'(ack), 1);
    rx_ack = 1'b0;
    write_byte(8'h69, 1'b1, 1'b0, ack); check("g_nack_d1", 32'(ack), 0);
    rx_ack = 1'b1;
    i2c_stop(); wait_cyc(20);
    check("g_rx_cnt", 32'(n_rx - rx0), 2);
    check("g_rx_last", 32'(rx_data), 32'h69);

    // Reset while the target drives a 0 read bit
    tx_q.push_back(8'h00);
    i2c_start();
    write_byte(8'hA1, 1'b0, 1'b0, ack); check("rr_ack_addr", 32'(ack), 1);
    wait_cyc(20);
    check("rr_driving", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("rr_async_rel", 32'(sda_oe), 0);
    check("rr_busy_rst", 32'(busy), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(10);
    rx_exp_q.push_back(8'hE7);
    i2c_start();
    write_byte(8'hA0, 1'b0, 1'b0, ack); check("rr_ack_addr2", 32'(ack), 1);
    write_byte(8'hE7, 1'b0, 1'b0, ack); check("rr_ack_d0", 32'(ack), 1);
    i2c_stop(); wait_cyc(20);
    check("rr_rx_data", 32'(rx_data), 32'hE7);
    check("rr_busy_end", 32'(busy), 0);

    check("rx_spurious", 32'(n_spur), 0);
    check("rx_q_left", 32'(rx_exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint: the responder to the team's I2C master and its clock generator. Oversamples raw SCL/SDA on the 100 MHz system clock, filters glitches, detects START/STOP, matches a 7-bit address, ACKs, and moves bytes to and from user logic through single-cycle strobes. Sits between the open-drain pad buffers and a register file or FIFO. Supports standard (100 kHz) and fast (400 kHz) mode; no clock stretching, no 10-bit addressing, no general call.

## Interface
- `ADDR`, 7'h50: own 7-bit target address.
- `FILTER_LEN`, 3: consecutive identical synchronized samples required before a filtered line changes; range 1–15.
- `clk`  in  1: system clock, 100 MHz.
- `rst_n`  in  1: reset; one clock, asynchronous, active-low.
- `scl_i`  in  1: raw SCL pad input, asynchronous.
- `sda_i`  in  1: raw SDA pad input, asynchronous.
- `sda_oe`  out  1: 1 = pull SDA low (open-drain); 0 = release.
- `rx_data`  out  8: last byte written by the master; holds until the next byte.
- `rx_valid`  out  1: one-cycle strobe, `rx_data` updated this cycle.
- `rx_ack`  in  1: 1 = ACK the current write byte, 0 = NACK; sampled at the ACK-slot drive point.
- `tx_data`  in  8: next byte to return on a read.
- `tx_req`  out  1: one-cycle strobe requesting `tx_data` for the next read byte.
- `rw`  out  1: R/W bit of the last matched address (1 = read).
- `busy`  out  1: high from START until STOP.
- `start_det`, `stop_det`  out  1 each: one-cycle strobes on (repeated) START / STOP.

## Operation
- Front end: each line passes a 2-flop synchronizer, then the filter. The filtered value changes only after `FILTER_LEN` consecutive samples differ from it. Filtered values reset to 1.
- Edges on filtered lines: SCL rise/fall; START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Data is sampled on SCL rise. SDA is changed only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- IDLE: START → ADDR, bit counter cleared.
- ADDR: shift SDA in MSB first on 8 rises. On the fall after the 8th rise:
  - shift[7:1]==`ADDR` → ADDR_ACK, `sda_oe`=1, `rw`=shift[0];
  - otherwise → WAIT_STOP with `sda_oe`=0.
- ADDR_ACK: if `rw`=1, `tx_req` pulses on the ACK-clock rise. On the ACK-clock fall:
  - `rw`=0 → RX, `sda_oe`=0;
  - `rw`=1 → capture `tx_data`, `sda_oe`=~tx_data[7], → TX.
- RX: 8 rises shift in a byte. On the 8th rise, `rx_data` is updated and `rx_valid` pulses in the same cycle. On the next fall → RX_ACK, `sda_oe`=`rx_ack`.
- RX_ACK: on fall, `sda_oe`=0 and → RX. NACKed bytes still produce `rx_valid`.
- TX: on each fall, drive the next bit (~bit → `sda_oe`). On the fall ending bit 0, `sda_oe`=0 → TX_ACK.
- TX_ACK: sample SDA on rise.
  - 0 (ACK) → `tx_req` pulses that cycle; on fall, capture `tx_data`, drive bit 7, → TX.
  - 1 (NACK) → WAIT_STOP.
- WAIT_STOP: `sda_oe`=0 and all SCL activity is ignored.
- START in any state → ADDR (repeated start), counter cleared, `sda_oe`=0 in the same cycle.
- STOP in any state → IDLE, `sda_oe`=0.
- START/STOP takes priority over any SCL edge detected in the same cycle.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_req`=0, `rw`=0, `busy`=0, `start_det`=0, `stop_det`=0, state IDLE. Reset mid-transfer releases SDA within the same cycle, asynchronously.
- Raw pad edge to filtered edge: 2 + `FILTER_LEN` cycles (5 by default). Register outputs follow one cycle later.
- `sda_oe` changes 6 cycles after a raw SCL fall (60 ns ≥ 0 ns t_HD;DAT). Changes land well before the next rise: 1.3 µs t_LOW in fast mode.
- Pulses narrower than `FILTER_LEN` cycles (30 ns) are rejected.
- `tx_req` leads the `tx_data` capture by the SCL high time (≥ 600 ns / 60 cycles); user logic must present `tx_data` within that time.
- `busy` rises with `start_det` and falls with `stop_det`.

## Test plan
- Write to 0x50 (0xA0, 0x3C, 0xC3, STOP) at 400 kHz → ACK on all 3 slots, `rx_valid` ×2 with 0x3C then 0xC3, `stop_det`, `busy` low.
- Address 0x51 write → `sda_oe` never asserted, no `rx_valid`, returns to IDLE on STOP.
- Read 0xA1, `tx_data`=0x5A then 0x81, master ACK then NACK → SDA carries 0x5A, 0x81; `tx_req` ×2; WAIT_STOP then IDLE.
- Write 0x50 data 0x11, repeated START, read → `start_det` ×2, `rw`=1, `busy` high throughout.
- 20 ns glitches on SCL during data bits; `rx_ack`=0 on byte 2 → correct `rx_data`, SDA high in the 2nd ACK slot.
- `rst_n` low during a read bit driving 0 → `sda_oe`=0 immediately; next START/address works normally.
